// File: rtl/time_of_day_counter.sv
// time_of_day_counter: BCD hh:mm:ss time-of-day counter for the seven-segment driver.
// The 1 Hz divider output and the debounced increment button are sampled as data
// in the CLK domain and turned into single-cycle tick / inc_pulse strobes.
// Modes: 00 run, 01 set hours, 10 set minutes, 11 hold. A one-cycle chime marks
// every hour rollover in run mode.
// Optional build macro HOUR12_EN: 12-hour display (12,01..11) with a registered pm flag;
// without it the counter runs 00..23 and pm is tied low.

// Synchronizer plus rising-edge detector producing a one-CLK strobe.
module tod_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic CLRn,
  input  logic din,
  output logic pulse_c
);

  logic [STAGES-1:0] sync;
  logic              dly;

  // Shift the asynchronous input through the sync chain, then one delay flop.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      dly  <= sync[STAGES-1];
    end
  end

  assign pulse_c = sync[STAGES-1] & ~dly;

endmodule

module time_of_day_counter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_HOUR  = 8'h00
) (
  input  logic       CLK,
  input  logic       CLRn,
  input  logic       clk_1HZ,
  input  logic [1:0] set_mode,
  input  logic       inc_btn,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic       chime
);

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  // Hour value loaded on reset; in 12-hour format a midnight reset shows as 12 AM.
`ifdef HOUR12_EN
  localparam logic [7:0] HOUR_RST = (RESET_HOUR == 8'h00) ? 8'h12 : RESET_HOUR;
`else
  localparam logic [7:0] HOUR_RST = RESET_HOUR;
`endif

  mode_e      mode_c;
  logic       tick_c;
  logic       inc_pulse_c;
  logic [7:0] hour_nxt;
  logic [7:0] min_nxt;
  logic [7:0] sec_nxt;
  logic       chime_nxt;
`ifdef HOUR12_EN
  logic       pm_nxt;
`endif

  assign mode_c = mode_e'(set_mode);

  // Two-digit BCD increment modulo 60 (seconds and minutes).
  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd9) begin
      r = {v[7:4], v[3:0] + 4'd1};
    end else if (v[7:4] != 4'd5) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

  // Two-digit BCD hour increment in the selected display format.
  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [7:0] r;
`ifdef HOUR12_EN
    if (v == 8'h12) begin
      r = 8'h01;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
`else
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
`endif
    return r;
  endfunction

  tod_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_1hz (
    .CLK     (CLK),
    .CLRn    (CLRn),
    .din     (clk_1HZ),
    .pulse_c (tick_c)
  );

  tod_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_btn (
    .CLK     (CLK),
    .CLRn    (CLRn),
    .din     (inc_btn),
    .pulse_c (inc_pulse_c)
  );

  // Next-state of the time registers; ticks act only in run, increments only in set modes.
  always_comb begin
    hour_nxt  = hour_bcd;
    min_nxt   = min_bcd;
    sec_nxt   = sec_bcd;
    chime_nxt = 1'b0;
`ifdef HOUR12_EN
    pm_nxt    = pm;
`endif
    unique case (mode_c)
      MODE_RUN: begin
        if (tick_c) begin
          sec_nxt = inc_mod60(sec_bcd);
          if (sec_bcd == 8'h59) begin
            min_nxt = inc_mod60(min_bcd);
            if (min_bcd == 8'h59) begin
              hour_nxt  = inc_hour(hour_bcd);
              chime_nxt = 1'b1;
`ifdef HOUR12_EN
              if (hour_bcd == 8'h11) begin
                pm_nxt = ~pm;
              end
`endif
            end
          end
        end
      end
      MODE_SET_HOUR: begin
        sec_nxt = 8'h00;
        if (inc_pulse_c) begin
          hour_nxt = inc_hour(hour_bcd);
`ifdef HOUR12_EN
          if (hour_bcd == 8'h11) begin
            pm_nxt = ~pm;
          end
`endif
        end
      end
      MODE_SET_MIN: begin
        sec_nxt = 8'h00;
        if (inc_pulse_c) begin
          min_nxt = inc_mod60(min_bcd);
        end
      end
      MODE_HOLD: begin
      end
      default: begin
      end
    endcase
  end

  // Time and chime registers.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      hour_bcd <= HOUR_RST;
      min_bcd  <= 8'h00;
      sec_bcd  <= 8'h00;
      chime    <= 1'b0;
    end else begin
      hour_bcd <= hour_nxt;
      min_bcd  <= min_nxt;
      sec_bcd  <= sec_nxt;
      chime    <= chime_nxt;
    end
  end

`ifdef HOUR12_EN
  // AM/PM flag, flipped on every 11->12 hour step.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      pm <= 1'b0;
    end else begin
      pm <= pm_nxt;
    end
  end
`else
  assign pm = 1'b0;
`endif

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Downstream consumer of the 1 Hz divider output; counts seconds, minutes and hours in BCD for the seven-segment display driver.
- Samples the divider's clk_1HZ square wave as data in the CLK domain. It is not used as a clock.
- Provides run, set-hours, set-minutes and hold modes driven by a debounced increment button.
- Emits a one-cycle chime pulse on every hour rollover.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on clk_1HZ and inc_btn (legal values ≥2).
- RESET_HOUR, 8'h00, BCD hour loaded on reset. 24h range 00-23; with HOUR12_EN, range 01-12.

Ports:
- CLK  input  1  system clock, 50 MHz.
- CLRn  input  1  asynchronous active-low reset.
- clk_1HZ  input  1  1 Hz square wave from the divider; its rising edge marks one second.
- set_mode  input  2  00 run, 01 set hours, 10 set minutes, 11 hold.
- inc_btn  input  1  debounced level, active-high; each rising edge is one increment.
- hour_bcd  output  8  hours, two BCD digits.
- min_bcd  output  8  minutes, two BCD digits.
- sec_bcd  output  8  seconds, two BCD digits.
- pm  output  1  PM flag. Constant 0 without HOUR12_EN.
- chime  output  1  one-CLK pulse on hour rollover.

Behaviour:
- Reset (CLRn low, asynchronous):
  - hour_bcd=RESET_HOUR, min_bcd=8'h00, sec_bcd=8'h00, pm=0, chime=0.
  - All synchronizer and edge-detect flops clear to 0. Consequently, clk_1HZ already high at reset release produces no tick.
- Tick generation:
  - clk_1HZ passes through SYNC_STAGES flops, then one delay flop.
  - tick = last sync stage AND NOT delay flop, i.e. high for exactly one CLK cycle.
  - Latency: clk_1HZ is first sampled high at CLK edge k; sec_bcd changes at edge k+SYNC_STAGES (edge k+2 at default).
  - inc_btn is synchronized and edge-detected identically to give inc_pulse.
- Run mode (00), on tick:
  - sec increments 00..59; at 59 it wraps to 00 and carries into min.
  - min increments 00..59; at 59 it wraps to 00 and carries into hour.
  - hour increments 00..23; at 23 it wraps to 00.
  - inc_pulse is ignored.
- BCD arithmetic:
  - The ones digit wraps 9→0 and carries into the tens digit.
  - Tens-digit limits are 5 for sec/min and 2 for hour (hour tens is 2 only with ones 0-3).
  - Illegal BCD codes cannot arise.
- chime:
  - Asserted for the single CLK cycle following the edge at which min and sec both roll 59→00 in run mode.
  - The 23:59:59→00:00:00 rollover also chimes.
  - Never asserted in the set modes or hold.
- Set hours (01):
  - sec is forced to 00 on the first CLK edge in this mode and held there. Ticks are ignored.
  - Each inc_pulse advances hour by one with wrap (23→00). No carry, no chime.
- Set minutes (10):
  - sec is forced to 00 and held there.
  - Each inc_pulse advances min with wrap (59→00). No carry into hour.
- Hold (11): all counters frozen; tick and inc_pulse ignored.
- Mode changes:
  - Take effect at the next CLK edge.
  - A tick in the same cycle as a change to 01/10/11 is dropped.
  - Returning to run resumes on the next tick; no second is added for time spent paused.
- Simultaneous tick and inc_pulse: cannot conflict. tick acts only in run mode, inc_pulse only in modes 01/10.
- Reset mid-operation: reset overrides everything immediately. No pending tick or increment survives.

Optional Feature:
- Macro: HOUR12_EN.
- When defined, hours use 12-hour format:
  - Sequence is 12,01,...,11,12.
  - pm toggles on the 11→12 transition, both on run-mode carry and on set-hours increment.
  - Reset value is RESET_HOUR with pm=0. The default RESET_HOUR of 8'h00 maps to 8'h12 (12 AM).
  - chime still fires on every hour rollover.
- When not defined: 24-hour format as above, and pm is tied to 0.

Test Plan:
- Reset, then a clk_1HZ rising edge at CLK edge k → sec_bcd=8'h01 after edge k+2. No change at k+1. chime stays 0.
- Preload to 00:59:59 via the set modes plus 59 ticks, then one tick → 01:00:00. chime high for exactly 1 CLK cycle.
- From 23:59:59, one tick → 00:00:00 with a chime pulse. Also drive 100 ticks and check 00:01:40.
- In set_mode=10 at min 59, one inc_btn pulse → min_bcd=8'h00, hour unchanged, sec_bcd=8'h00. A concurrent tick causes no change.
- In hold (11) at 05:30:17, 5 ticks → 05:30:17. Switch to 00 and apply 1 tick → 05:30:18. Assert CLRn low mid-count → 00:00:00 immediately, without waiting for a CLK edge.
- HOUR12_EN build, 11:59:59 with pm=0, one tick → 12:00:00 with pm=1. In set hours from 12, one inc_btn pulse → 01 with pm unchanged.
